// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, one outstanding bus request, registered decode slot plus one skid entry.
// Zero-latency memory gives one instruction per cycle; a stalled slot parks one response in the skid and pauses requests.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_SKID  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] fetch_pc, fetch_pc_nxt;
  logic [63:0] pend_pc, pend_pc_nxt;
  logic [63:0] skid_pc, skid_pc_nxt;
  logic [31:0] skid_instr, skid_instr_nxt;
  logic        out_valid_nxt;
  logic [63:0] out_pc_nxt;
  logic [31:0] out_instr_nxt;
  logic        slot_xfer;
  logic        slot_free;

  // The request is state-decoded; FLUSH keeps presenting the abandoned address until it completes.
  assign ireq_valid = !reset && (state != S_SKID);
  assign ireq_addr  = fetch_pc;

  assign slot_xfer = out_valid && out_ready;
  assign slot_free = !out_valid || out_ready;

  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    pend_pc_nxt    = pend_pc;
    skid_pc_nxt    = skid_pc;
    skid_instr_nxt = skid_instr;
    out_valid_nxt  = out_valid && !slot_xfer;
    out_pc_nxt     = out_pc;
    out_instr_nxt  = out_instr;

    case (state)
      S_REQ: begin
        if (redirect_valid) begin
          if (iresp_data_ok) begin
            fetch_pc_nxt = redirect_pc;
          end else begin
            pend_pc_nxt = redirect_pc;
            state_nxt   = S_FLUSH;
          end
        end else if (iresp_data_ok) begin
          fetch_pc_nxt = fetch_pc + 64'd4;
          if (slot_free) begin
            out_valid_nxt = 1'b1;
            out_pc_nxt    = fetch_pc;
            out_instr_nxt = iresp_data;
          end else begin
            skid_pc_nxt    = fetch_pc;
            skid_instr_nxt = iresp_data;
            state_nxt      = S_SKID;
          end
        end
      end

      S_SKID: begin
        if (redirect_valid) begin
          skid_pc_nxt    = '0;
          skid_instr_nxt = '0;
          fetch_pc_nxt   = redirect_pc;
          state_nxt      = S_REQ;
        end else if (slot_xfer) begin
          out_valid_nxt = 1'b1;
          out_pc_nxt    = skid_pc;
          out_instr_nxt = skid_instr;
          state_nxt     = S_REQ;
        end
      end

      S_FLUSH: begin
        if (redirect_valid) begin
          pend_pc_nxt = redirect_pc;
        end
        // Wrong-path data is discarded; the newest redirect target wins.
        if (iresp_data_ok) begin
          fetch_pc_nxt = redirect_valid ? redirect_pc : pend_pc;
          state_nxt    = S_REQ;
        end
      end

      default: begin
        state_nxt = S_REQ;
      end
    endcase

    if (redirect_valid) begin
      out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      fetch_pc   <= RESET_PC;
      pend_pc    <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_instr  <= '0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      pend_pc    <= pend_pc_nxt;
      skid_pc    <= skid_pc_nxt;
      skid_instr <= skid_instr_nxt;
      out_valid  <= out_valid_nxt;
      out_pc     <= out_pc_nxt;
      out_instr  <= out_instr_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scenario tasks drive the bus/redirect/decode side; a scoreboard checks every delivered instruction.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_pc;

  logic        prev_req;
  logic        prev_ok;
  logic        prev_rst;
  logic [63:0] prev_addr;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  // Scoreboard and bus-hold monitor; samples just after the falling edge, once inputs for the next edge are set.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (reset === 1'b0) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got pc=%h instr=%h expected no delivery", out_pc, out_instr);
        end else begin
          e = sb.pop_front();
          if (out_pc !== e.pc || out_instr !== e.instr) begin
            errors++;
            $display("FAIL sb_order: got pc=%h instr=%h expected pc=%h instr=%h",
                     out_pc, out_instr, e.pc, e.instr);
          end
        end
      end
      if (prev_req === 1'b1 && prev_ok === 1'b0 && prev_rst === 1'b0) begin
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== prev_addr) begin
          errors++;
          $display("FAIL bus_hold: got valid=%b addr=%h expected valid=1 addr=%h",
                   ireq_valid, ireq_addr, prev_addr);
        end
      end
    end
    prev_req  = ireq_valid;
    prev_ok   = iresp_data_ok;
    prev_rst  = reset;
    prev_addr = ireq_addr;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    idle_inputs();
    repeat (2) step();
    checks++;
    if (ireq_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ireq_valid: got %b expected 0", ireq_valid);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_pc !== 64'd0 || out_instr !== 32'd0) begin
      errors++; $display("FAIL reset_slot: got pc=%h instr=%h expected 0/0", out_pc, out_instr);
    end
    reset = 1'b0;
    sb.delete();
    exp_pc = RST_PC;
    step();
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== RST_PC) begin
      errors++; $display("FAIL first_req: got valid=%b addr=%h expected 1/%h", ireq_valid, ireq_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] d;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 32'h0000_0013 | (i << 20);
      checks++;
      if (ireq_valid !== 1'b1 || ireq_addr !== exp_pc) begin
        errors++; $display("FAIL stream_req: got valid=%b addr=%h expected 1/%h", ireq_valid, ireq_addr, exp_pc);
      end
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== exp_pc - 64'd4) begin
          errors++; $display("FAIL stream_out: got valid=%b pc=%h expected 1/%h", out_valid, out_pc, exp_pc - 64'd4);
        end
      end
      iresp_data_ok = 1'b1;
      iresp_data    = d;
      sb.push_back({exp_pc, d});
      exp_pc += 64'd4;
      step();
    end
    idle_inputs();
    step();
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL stream_drain: got valid=%b pending=%0d expected 0/0", out_valid, sb.size());
    end
  endtask

  task automatic test_skid();
    logic [63:0] p0;
    p0 = exp_pc;
    out_ready = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data = 32'h0010_0093;
    sb.push_back({exp_pc, iresp_data});
    exp_pc += 64'd4;
    step();
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== exp_pc) begin
      errors++; $display("FAIL skid_second_req: got valid=%b addr=%h expected 1/%h", ireq_valid, ireq_addr, exp_pc);
    end
    iresp_data = 32'h0020_0113;
    sb.push_back({exp_pc, iresp_data});
    exp_pc += 64'd4;
    step();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ireq_valid !== 1'b0 || out_valid !== 1'b1 || out_pc !== p0) begin
        errors++; $display("FAIL skid_hold: got req=%b valid=%b pc=%h expected 0/1/%h", ireq_valid, out_valid, out_pc, p0);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== p0 + 64'd4 || out_instr !== 32'h0020_0113) begin
      errors++; $display("FAIL skid_release: got valid=%b pc=%h instr=%h expected 1/%h/00200113",
                         out_valid, out_pc, out_instr, p0 + 64'd4);
    end
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== exp_pc) begin
      errors++; $display("FAIL skid_resume: got valid=%b addr=%h expected 1/%h", ireq_valid, ireq_addr, exp_pc);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL skid_drain: got valid=%b pending=%0d expected 0/0", out_valid, sb.size());
    end
  endtask

  task automatic test_flush();
    logic [63:0] p;
    p = exp_pc;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    step();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ireq_valid !== 1'b1 || ireq_addr !== p || out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_hold: got req=%b addr=%h valid=%b expected 1/%h/0", ireq_valid, ireq_addr, out_valid, p);
      end
      step();
    end
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0100 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_target: got req=%b addr=%h valid=%b expected 1/80000100/0", ireq_valid, ireq_addr, out_valid);
    end
    exp_pc = 64'h8000_0100;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_dropped: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_redirect_data();
    out_ready = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data = 32'h0030_0193;
    sb.push_back({exp_pc, iresp_data});
    exp_pc += 64'd4;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0200;
    iresp_data = 32'hBAD0_BAD0;
    step();
    idle_inputs();
    void'(sb.pop_back());
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL redir_kill_slot: got valid=%b expected 0", out_valid);
    end
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0200) begin
      errors++; $display("FAIL redir_same_cycle: got req=%b addr=%h expected 1/80000200", ireq_valid, ireq_addr);
    end
    exp_pc = 64'h8000_0200;
    out_ready = 1'b1;
  endtask

  task automatic test_skid_redirect();
    out_ready = 1'b0;
    iresp_data_ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iresp_data = 32'h0040_0213 + k;
      sb.push_back({exp_pc, iresp_data});
      exp_pc += 64'd4;
      step();
    end
    idle_inputs();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0280;
    step();
    idle_inputs();
    void'(sb.pop_back());
    checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0280) begin
      errors++; $display("FAIL skid_redirect: got valid=%b req=%b addr=%h expected 0/1/80000280", out_valid, ireq_valid, ireq_addr);
    end
    exp_pc = 64'h8000_0280;
    step();
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL skid_redirect_drain: got pending=%0d valid=%b expected 0/0", sb.size(), out_valid);
    end
  endtask

  task automatic test_double_flush();
    logic [63:0] p;
    p = exp_pc;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0300;
    step();
    redirect_pc = 64'h8000_0400;
    step();
    idle_inputs();
    checks++;
    if (ireq_addr !== p) begin
      errors++; $display("FAIL dflush_hold: got addr=%h expected %h", ireq_addr, p);
    end
    iresp_data_ok = 1'b1;
    iresp_data = 32'h1111_1111;
    step();
    idle_inputs();
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0400 || out_valid !== 1'b0) begin
      errors++; $display("FAIL dflush_newest: got req=%b addr=%h valid=%b expected 1/80000400/0", ireq_valid, ireq_addr, out_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0500;
    step();
    redirect_pc = 64'h8000_0600;
    iresp_data_ok = 1'b1;
    iresp_data = 32'h2222_2222;
    step();
    idle_inputs();
    checks++;
    if (ireq_addr !== 64'h8000_0600 || out_valid !== 1'b0) begin
      errors++; $display("FAIL dflush_coincide: got addr=%h valid=%b expected 80000600/0", ireq_addr, out_valid);
    end
    exp_pc = 64'h8000_0600;
  endtask

  task automatic test_wrap();
    iresp_data_ok = 1'b1;
    iresp_data = 32'h3333_3333;
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    idle_inputs();
    exp_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    checks++;
    if (ireq_addr !== exp_pc || out_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_target: got addr=%h valid=%b expected %h/0", ireq_addr, out_valid, exp_pc);
    end
    iresp_data_ok = 1'b1;
    iresp_data = 32'h0000_0073;
    sb.push_back({exp_pc, iresp_data});
    exp_pc += 64'd4;
    step();
    idle_inputs();
    checks++;
    if (ireq_addr !== exp_pc || out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++; $display("FAIL wrap_next: got addr=%h out_pc=%h expected %h/fffffffffffffffc", ireq_addr, out_pc, exp_pc);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      iresp_data_ok = 1'b0;
      if (ireq_valid === 1'b1) begin
        checks++;
        if (ireq_addr !== exp_pc) begin
          errors++; $display("FAIL rand_addr: got %h expected %h", ireq_addr, exp_pc);
        end
        if ($urandom_range(0, 2) != 0) begin
          iresp_data_ok = 1'b1;
          iresp_data = $urandom;
          sb.push_back({exp_pc, iresp_data});
          exp_pc += 64'd4;
        end
      end
      step();
    end
    idle_inputs();
    out_ready = 1'b1;
    for (int c = 0; c < 8 && (sb.size() != 0 || out_valid !== 1'b0); c++) step();
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rand_drain: got pending=%0d valid=%b expected 0/0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset_skid();
    out_ready = 1'b0;
    iresp_data_ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iresp_data = 32'h0050_0293 + k;
      sb.push_back({exp_pc, iresp_data});
      exp_pc += 64'd4;
      step();
    end
    idle_inputs();
    checks++;
    if (ireq_valid !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rskid_enter: got req=%b valid=%b expected 0/1", ireq_valid, out_valid);
    end
    reset = 1'b1;
    step();
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b0) begin
      errors++; $display("FAIL rskid_reset: got valid=%b req=%b expected 0/0", out_valid, ireq_valid);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    exp_pc = RST_PC;
    step();
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== RST_PC) begin
      errors++; $display("FAIL rskid_restart: got req=%b addr=%h expected 1/%h", ireq_valid, ireq_addr, RST_PC);
    end
    iresp_data_ok = 1'b1;
    iresp_data = 32'h0060_0313;
    sb.push_back({exp_pc, iresp_data});
    exp_pc += 64'd4;
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== RST_PC) begin
      errors++; $display("FAIL rskid_first_out: got valid=%b pc=%h expected 1/%h", out_valid, out_pc, RST_PC);
    end
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL rskid_drain: got pending=%0d expected 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    idle_inputs();
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_redirect_data();
    test_skid_redirect();
    test_double_flush();
    test_wrap();
    test_back_to_back();
    test_reset_skid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage at the head of the pipeline.
- Owns the architectural fetch PC and issues one-outstanding instruction-bus requests.
- Presents {valid, pc, raw_instr} to decode through a valid/ready output slot.
- Redirects come from execute (branch/jump) and flush any wrong-path fetch, including one still in flight on the bus.

Parameters:
RESET_PC, 64'h8000_0000, fetch PC loaded by reset.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
ireq_valid  output  1  instruction-bus request valid.
ireq_addr  output  64  request address (fetch PC).
iresp_data_ok  input  1  response valid; completes the outstanding request.
iresp_data  input  32  fetched instruction, valid with iresp_data_ok.
redirect_valid  input  1  execute-stage redirect (taken branch, jal, jalr).
redirect_pc  input  64  redirect target; bits [1:0] are zero.
out_valid  output  1  slot holds an instruction for decode.
out_pc  output  64  PC of the slot instruction.
out_instr  output  32  raw instruction word.
out_ready  input  1  decode accepts the slot this cycle (not stalled).

Behaviour:
- Reset, applied at a clock edge:
  - state=REQ, fetch_pc=RESET_PC, out_valid=0, skid empty.
  - out_pc=0, out_instr=0, pend_pc=0.
  - ireq_valid=0 while reset is high. First request (addr RESET_PC) is in the first cycle after reset deasserts.
  - Reset mid-transaction abandons everything, and the bus is assumed reset alongside.
- Bus rule: once ireq_valid rises, ireq_valid and ireq_addr stay constant until the cycle iresp_data_ok=1. Only one request is outstanding. Minimum latency is data_ok in the same cycle as the request.
- Slot transfer happens when out_valid && out_ready. Slot contents stay stable while out_valid && !out_ready.
- State REQ (ireq_valid=1, ireq_addr=fetch_pc):
  - redirect_valid && data_ok: drop the data; fetch_pc<=redirect_pc; stay REQ.
  - redirect_valid && !data_ok: pend_pc<=redirect_pc; go to FLUSH.
  - data_ok, no redirect, slot empty or transferring this cycle: slot<={1,fetch_pc,iresp_data}; fetch_pc<=fetch_pc+4; stay REQ. Throughput is one instruction per cycle with zero-latency memory.
  - data_ok, no redirect, slot full and not transferring: skid<=iresp_data; skid_pc<=fetch_pc; fetch_pc<=fetch_pc+4; go to SKID.
- State SKID (ireq_valid=0):
  - redirect_valid: clear skid; fetch_pc<=redirect_pc; go to REQ.
  - Otherwise, on slot transfer: slot<={1,skid_pc,skid}; go to REQ.
- State FLUSH (ireq_valid=1, ireq_addr unchanged from the abandoned request):
  - A further redirect_valid overwrites pend_pc; the newest target wins.
  - On data_ok: discard the data; fetch_pc<=pend_pc (or redirect_pc if a redirect coincides); go to REQ.
- Any redirect_valid clears out_valid on the next edge, regardless of out_ready. A transfer in the same cycle as a redirect still counts as a transfer for decode; the redirect source kills it downstream.
- Redirect has priority over every other event in the same cycle.
- fetch_pc+4 wraps modulo 2^64.
- All outputs are registered or state-decoded; there is no combinational path from out_ready to ireq_valid.

Test Plan:
- Reset, then 1-cycle data_ok with out_ready=1 and instrs 0x00000013 ×4 → ireq_addr 0x80000000, 0x80000004, 0x80000008, 0x8000000C; out_pc follows one cycle later; one instruction per cycle.
- out_ready=0 for 3 cycles while data_ok arrives → SKID entered, ireq_valid=0; slot holds 0x80000000 and skid holds 0x80000004; on release, out_pc 0x80000004 appears next cycle and the request to 0x80000008 resumes. No instruction is lost or duplicated.
- Request to 0x80000010 outstanding, data_ok delayed 4 cycles, redirect to 0x80000100 in cycle 1 → ireq_addr stays 0x80000010 until data_ok; the data never reaches out_valid; next request is 0x80000100.
- Redirect to 0x80000200 in the same cycle as data_ok → data dropped; next ireq_addr 0x80000200; out_valid=0 the next cycle.
- Two redirects during FLUSH (0x80000300, then 0x80000400) → first post-flush request is 0x80000400.
- Reset asserted while in SKID with out_valid=1 → next cycle out_valid=0 and ireq_valid=0; after release, fetch restarts at 0x80000000.
